// File: rtl/decode_stage_pkg.sv
// Shared definitions for the decode stage: control-vector bit indices,
// MIPS opcode/funct constants and a helper that builds one-hot control bits.
package decode_stage_pkg;

  // Control vector layout
  localparam int CONTROL_REG_SIZE = 9;
  localparam int REG_WE  = 0;
  localparam int I_TYPE  = 1;
  localparam int R_TYPE  = 2;
  localparam int J_TYPE  = 3;
  localparam int MEM_WE  = 4;
  localparam int MEM_WB  = 5;
  localparam int BRANCH  = 6;
  localparam int JUMP    = 7;
  localparam int ILLEGAL = 8;

  // Primary opcodes (insn[0:5])
  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_JAL    = 6'b000011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;
  localparam logic [5:0] OP_ADDIU  = 6'b001001;
  localparam logic [5:0] OP_SLTI   = 6'b001010;
  localparam logic [5:0] OP_ORI    = 6'b001101;
  localparam logic [5:0] OP_LUI    = 6'b001111;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SW     = 6'b101011;

  // R-type funct and REGIMM rt sub-codes
  localparam logic [5:0] FUNCT_JR = 6'b001000;
  localparam logic [4:0] RT_BLTZ  = 5'b00000;
  localparam logic [4:0] RT_BGEZ  = 5'b00001;

  function automatic logic [CONTROL_REG_SIZE-1:0] ctrl_bit(input int idx);
    return CONTROL_REG_SIZE'(1) << idx;
  endfunction

endpackage

// File: rtl/decode_regfile.sv
// Register file for the decode stage: two combinational read ports with
// same-cycle write-back bypass, one write port, register 0 hard-wired to zero.
module decode_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  localparam int ADDR_W    = $clog2(NUM_REGS)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     ra1,
  input  logic [ADDR_W-1:0]     ra2,
  input  logic [ADDR_W-1:0]     wa,
  input  logic [DATA_WIDTH-1:0] wd,
  input  logic                  we,
  output logic [DATA_WIDTH-1:0] rd1,
  output logic [DATA_WIDTH-1:0] rd2
);

  logic [DATA_WIDTH-1:0] mem_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] mem_d [NUM_REGS];

  // Next register-file contents: apply the write-back, never to register 0.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    mem_d = mem_q;
    if (we && wa != '0) mem_d[wa] = wd;
  end

  // Storage update; only reset blocks write-back.
  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: storage is cleared on reset because software expects all registers to start at zero.
      for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
      mem_q <= mem_d;
    end
  end

  // Read ports: register 0 is zero, a same-cycle write to the read index wins.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (ra1 != '0) rd1 = (we && wa == ra1) ? wd : mem_q[ra1];
    if (ra2 != '0) rd2 = (we && wa == ra2) ? wd : mem_q[ra2];
  end

endmodule

// File: rtl/decode_stage.sv
// MIPS ID stage: decodes one instruction per cycle into a registered control
// vector, destination, extended immediate and operands, with valid/stall/flush
// handshake and load-use bubble insertion.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int REG_ADDR_W = 5,
  parameter int LINK_REG   = 31
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [0:31]                 insn,
  input  logic                        insn_valid,
  input  logic [DATA_WIDTH-1:0]       pc,
  input  logic                        stall_in,
  input  logic                        flush,
  input  logic [REG_ADDR_W-1:0]       wb_rd,
  input  logic [DATA_WIDTH-1:0]       wb_data,
  input  logic                        wb_we,
  output logic                        out_valid,
  output logic [DATA_WIDTH-1:0]       pc_out,
  output logic [0:31]                 ir_out,
  output logic [DATA_WIDTH-1:0]       rs_data,
  output logic [DATA_WIDTH-1:0]       rt_data,
  output logic [DATA_WIDTH-1:0]       imm_ext,
  output logic [REG_ADDR_W-1:0]       rd_out,
  output logic [CONTROL_REG_SIZE-1:0] control,
  output logic                        stall_out
);

  // Instruction fields (big-endian bit numbering, insn[0] is the MSB)
  logic [5:0]            opcode, funct;
  logic [REG_ADDR_W-1:0] rs, rt, rd_f;
  logic [15:0]           imm16;
  assign opcode = insn[0:5];
  assign rs     = REG_ADDR_W'(insn[6:10]);
  assign rt     = REG_ADDR_W'(insn[11:15]);
  assign rd_f   = REG_ADDR_W'(insn[16:20]);
  assign funct  = insn[26:31];
  assign imm16  = insn[16:31];

  logic [CONTROL_REG_SIZE-1:0] dec_ctrl;
  logic [REG_ADDR_W-1:0]       dec_rd;
  logic [DATA_WIDTH-1:0]       dec_imm;
  logic                        uses_rs, uses_rt, hazard;
  logic [DATA_WIDTH-1:0]       rf_rs, rf_rt;

  decode_regfile #(.DATA_WIDTH(DATA_WIDTH), .NUM_REGS(NUM_REGS)) u_regfile (
    .clock (clock),
    .reset (reset),
    .ra1   (rs),
    .ra2   (rt),
    .wa    (wb_rd),
    .wd    (wb_data),
    .we    (wb_we),
    .rd1   (rf_rs),
    .rd2   (rf_rt)
  );

  // Instruction decode. Immediate defaults to sign extension; ORI and LUI override.
  always_comb begin
    dec_ctrl = '0;
    dec_rd   = '0;
    dec_imm  = {{(DATA_WIDTH-16){imm16[15]}}, imm16};
    uses_rs  = 1'b0;
    uses_rt  = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        uses_rs = 1'b1;
        uses_rt = 1'b1;
        if (funct == FUNCT_JR) begin
          dec_ctrl = ctrl_bit(JUMP);
        end else begin
          dec_ctrl = ctrl_bit(R_TYPE) | ctrl_bit(REG_WE);
          dec_rd   = rd_f;
        end
      end
      OP_ADDIU, OP_SLTI: begin
        uses_rs  = 1'b1;
        dec_ctrl = ctrl_bit(I_TYPE) | ctrl_bit(REG_WE);
        dec_rd   = rt;
      end
      OP_ORI: begin
        uses_rs  = 1'b1;
        dec_ctrl = ctrl_bit(I_TYPE) | ctrl_bit(REG_WE);
        dec_rd   = rt;
        dec_imm  = DATA_WIDTH'(imm16);
      end
      OP_LUI: begin
        dec_ctrl = ctrl_bit(I_TYPE) | ctrl_bit(REG_WE);
        dec_rd   = rt;
        dec_imm  = DATA_WIDTH'({imm16, 16'h0000});
      end
      OP_LW: begin
        uses_rs  = 1'b1;
        dec_ctrl = ctrl_bit(I_TYPE) | ctrl_bit(REG_WE) | ctrl_bit(MEM_WB);
        dec_rd   = rt;
      end
      OP_SW: begin
        uses_rs  = 1'b1;
        uses_rt  = 1'b1;
        dec_ctrl = ctrl_bit(I_TYPE) | ctrl_bit(MEM_WE);
      end
      OP_BEQ, OP_BNE: begin
        uses_rs  = 1'b1;
        uses_rt  = 1'b1;
        dec_ctrl = ctrl_bit(J_TYPE) | ctrl_bit(BRANCH);
      end
      OP_BLEZ, OP_BGTZ: begin
        uses_rs  = 1'b1;
        dec_ctrl = ctrl_bit(J_TYPE) | ctrl_bit(BRANCH);
      end
      OP_REGIMM: begin
        uses_rs  = 1'b1;
        dec_ctrl = ctrl_bit(J_TYPE) | ctrl_bit(BRANCH);
        if (rt != RT_BLTZ && rt != RT_BGEZ) dec_ctrl = dec_ctrl | ctrl_bit(ILLEGAL);
      end
      OP_J:    dec_ctrl = ctrl_bit(J_TYPE) | ctrl_bit(JUMP);
      OP_JAL: begin
        dec_ctrl = ctrl_bit(J_TYPE) | ctrl_bit(JUMP) | ctrl_bit(REG_WE);
        dec_rd   = REG_ADDR_W'(LINK_REG);
      end
      default: dec_ctrl = ctrl_bit(ILLEGAL);
    endcase
    // The all-zero word is a NOP rather than an R-type write to r0.
    if (insn == '0) begin
      dec_ctrl = '0;
      uses_rs  = 1'b0;
      uses_rt  = 1'b0;
    end
    if (!dec_ctrl[REG_WE]) dec_rd = '0;
  end

  // Load-use hazard: the load now in execute targets a register this insn reads.
  always_comb begin
    hazard = insn_valid && out_valid && control[MEM_WB] && (rd_out != '0) &&
             ((uses_rs && rd_out == rs) || (uses_rt && rd_out == rt));
  end

  assign stall_out = stall_in | hazard;

  logic                        out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]       pc_q, pc_d, rs_data_q, rs_data_d, rt_data_q, rt_data_d;
  logic [DATA_WIDTH-1:0]       imm_ext_q, imm_ext_d;
  logic [0:31]                 ir_q, ir_d;
  logic [REG_ADDR_W-1:0]       rd_q, rd_d;
  logic [CONTROL_REG_SIZE-1:0] control_q, control_d;

  // Output register next-state: flush > stall_in > hazard > normal decode.
  always_comb begin
    out_valid_d = out_valid_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    rs_data_d   = rs_data_q;
    rt_data_d   = rt_data_q;
    imm_ext_d   = imm_ext_q;
    rd_d        = rd_q;
    control_d   = control_q;
    if (flush || (!stall_in && hazard)) begin
      out_valid_d = 1'b0;
      control_d   = '0;
    end else if (!stall_in) begin
      out_valid_d = insn_valid;
      pc_d        = pc;
      ir_d        = insn;
      rs_data_d   = rf_rs;
      rt_data_d   = rf_rt;
      imm_ext_d   = dec_imm;
      rd_d        = insn_valid ? dec_rd : '0;
      control_d   = insn_valid ? dec_ctrl : '0;
    end
  end

  // Output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      pc_q        <= '0;
      ir_q        <= '0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      imm_ext_q   <= '0;
      rd_q        <= '0;
      control_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      rs_data_q   <= rs_data_d;
      rt_data_q   <= rt_data_d;
      imm_ext_q   <= imm_ext_d;
      rd_q        <= rd_d;
      control_q   <= control_d;
    end
  end

  assign out_valid = out_valid_q;
  assign pc_out    = pc_q;
  assign ir_out    = ir_q;
  assign rs_data   = rs_data_q;
  assign rt_data   = rt_data_q;
  assign imm_ext   = imm_ext_q;
  assign rd_out    = rd_q;
  assign control   = control_q;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed test-plan sequence with
// literal expectations, then randomized traffic against a behavioural model.
module tb_decode_stage;

  // Control-vector bit weights, written out independently of the design package
  localparam logic [8:0] C_WE = 9'h001, C_I = 9'h002, C_R = 9'h004, C_J = 9'h008;
  localparam logic [8:0] C_MW = 9'h010, C_LD = 9'h020, C_BR = 9'h040, C_JP = 9'h080;
  localparam logic [8:0] C_IL = 9'h100;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] insn = '0;
  logic        insn_valid = 1'b0;
  logic [31:0] pc = '0;
  logic        stall_in = 1'b0, flush = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        wb_we = 1'b0;

  logic        out_valid, stall_out;
  logic [31:0] pc_out, ir_out, rs_data, rt_data, imm_ext;
  logic [4:0]  rd_out;
  logic [8:0]  control;

  decode_stage dut (
    .clock(clock), .reset(reset), .insn(insn), .insn_valid(insn_valid), .pc(pc),
    .stall_in(stall_in), .flush(flush), .wb_rd(wb_rd), .wb_data(wb_data), .wb_we(wb_we),
    .out_valid(out_valid), .pc_out(pc_out), .ir_out(ir_out), .rs_data(rs_data),
    .rt_data(rt_data), .imm_ext(imm_ext), .rd_out(rd_out), .control(control),
    .stall_out(stall_out)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic        ov;
    logic [31:0] pc, ir, rs, rt, imm;
    logic [4:0]  rd;
    logic [8:0]  ctrl;
  } exp_t;

  exp_t        m;
  logic [31:0] regs [32];

  // What each instruction means, straight from the opcode table.
  function automatic void ref_decode(input logic [31:0] i, output logic [8:0] c,
                                     output logic [4:0] d, output logic [31:0] im,
                                     output logic urs, output logic urt);
    logic [5:0]  op;
    logic [4:0]  f_rt;
    op   = i[31:26];
    f_rt = i[20:16];
    c = '0; d = '0; urs = 1'b0; urt = 1'b0;
    im = {{16{i[15]}}, i[15:0]};
    if (i == 32'h0) begin
      c = '0;
    end else if (op == 6'b000000 && i[5:0] == 6'b001000) begin
      c = C_JP; urs = 1'b1; urt = 1'b1;
    end else if (op == 6'b000000) begin
      c = C_R | C_WE; d = i[15:11]; urs = 1'b1; urt = 1'b1;
    end else if (op == 6'b001001 || op == 6'b001010) begin
      c = C_I | C_WE; d = f_rt; urs = 1'b1;
    end else if (op == 6'b001101) begin
      c = C_I | C_WE; d = f_rt; urs = 1'b1; im = {16'h0, i[15:0]};
    end else if (op == 6'b001111) begin
      c = C_I | C_WE; d = f_rt; im = {i[15:0], 16'h0};
    end else if (op == 6'b100011) begin
      c = C_I | C_WE | C_LD; d = f_rt; urs = 1'b1;
    end else if (op == 6'b101011) begin
      c = C_I | C_MW; urs = 1'b1; urt = 1'b1;
    end else if (op == 6'b000100 || op == 6'b000101) begin
      c = C_J | C_BR; urs = 1'b1; urt = 1'b1;
    end else if (op == 6'b000110 || op == 6'b000111) begin
      c = C_J | C_BR; urs = 1'b1;
    end else if (op == 6'b000001) begin
      c = C_J | C_BR | ((f_rt > 5'd1) ? C_IL : 9'h0); urs = 1'b1;
    end else if (op == 6'b000010) begin
      c = C_J | C_JP;
    end else if (op == 6'b000011) begin
      c = C_J | C_JP | C_WE; d = 5'd31;
    end else begin
      c = C_IL;
    end
  endfunction

  function automatic logic [31:0] rf_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'h0;
    if (wb_we && wb_rd == idx) return wb_data;
    return regs[idx];
  endfunction

  function automatic logic m_hazard();
    logic [8:0] c; logic [4:0] d; logic [31:0] im; logic urs, urt;
    ref_decode(insn, c, d, im, urs, urt);
    return insn_valid && m.ov && m.ctrl[5] && m.rd != 0 &&
           ((urs && m.rd == insn[25:21]) || (urt && m.rd == insn[20:16]));
  endfunction

  // Advance the model by one clock edge using the inputs the DUT just sampled.
  task automatic model_step();
    logic [8:0] c; logic [4:0] d; logic [31:0] im; logic urs, urt;
    if (reset) begin
      m = '0;
      for (int k = 0; k < 32; k++) regs[k] = '0;
    end else begin
      ref_decode(insn, c, d, im, urs, urt);
      if (flush || (!stall_in && m_hazard())) begin
        m.ov = 1'b0; m.ctrl = '0;
      end else if (!stall_in) begin
        m.ov  = insn_valid;
        m.pc  = pc;
        m.ir  = insn;
        m.rs  = rf_read(insn[25:21]);
        m.rt  = rf_read(insn[20:16]);
        m.imm = im;
        m.rd  = insn_valid ? d : 5'd0;
        m.ctrl = insn_valid ? c : 9'd0;
      end
      if (wb_we && wb_rd != 0) regs[wb_rd] = wb_data;
    end
  endtask

  // Compare every output against the model once per cycle.
  always @(negedge clock) begin
    if (chk_en) begin
      check("out_valid", 64'(out_valid), 64'(m.ov));
      check("pc_out",    64'(pc_out),    64'(m.pc));
      check("ir_out",    64'(ir_out),    64'(m.ir));
      check("rs_data",   64'(rs_data),   64'(m.rs));
      check("rt_data",   64'(rt_data),   64'(m.rt));
      check("imm_ext",   64'(imm_ext),   64'(m.imm));
      check("rd_out",    64'(rd_out),    64'(m.rd));
      check("control",   64'(control),   64'(m.ctrl));
      check("stall_out", 64'(stall_out), 64'(stall_in | m_hazard()));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cycle();
    @(posedge clock);
    model_step();
    chk_en = 1'b1;
    #2;
  endtask

  task automatic settle();
    @(negedge clock);
    #1;
  endtask

  task automatic put(input logic [31:0] i, input logic [31:0] p);
    insn = i; pc = p; insn_valid = 1'b1;
  endtask

  function automatic logic [31:0] rand_insn();
    logic [4:0]  r1, r2, r3;
    logic [15:0] im;
    r1 = 5'($urandom_range(0, 7));
    r2 = 5'($urandom_range(0, 7));
    r3 = 5'($urandom_range(0, 7));
    im = 16'($urandom);
    case ($urandom_range(0, 15))
      0:  return {6'b000000, r1, r2, r3, 5'd0, 6'b100001};
      1:  return {6'b000000, r1, 15'd0, 6'b001000};
      2:  return {6'b001001, r1, r2, im};
      3:  return {6'b001010, r1, r2, im};
      4:  return {6'b001101, r1, r2, im};
      5:  return {6'b001111, 5'd0, r2, im};
      6, 7: return {6'b100011, r1, r2, im};
      8:  return {6'b101011, r1, r2, im};
      9:  return {6'b000100, r1, r2, im};
      10: return {6'b000101, r1, r2, im};
      11: return {($urandom_range(0, 1) != 0) ? 6'b000110 : 6'b000111, r1, 5'd0, im};
      12: return {6'b000001, r1, 5'($urandom_range(0, 3)), im};
      13: return {($urandom_range(0, 1) != 0) ? 6'b000010 : 6'b000011, 26'($urandom)};
      14: return 32'h0;
      default: return {($urandom_range(0, 1) != 0) ? 6'b111111 : 6'b010000, 26'($urandom)};
    endcase
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    for (int k = 0; k < 32; k++) regs[k] = '0;
    m = '0;

    // Reset
    reset = 1'b1;
    cycle(); cycle();
    reset = 1'b0;
    settle();
    check("lit reset out_valid", 64'(out_valid), 64'd0);
    check("lit reset control",   64'(control),   64'd0);
    check("lit reset pc_out",    64'(pc_out),    64'd0);

    // ADDIU r2,r1,0xFFFF
    put({6'b001001, 5'd1, 5'd2, 16'hFFFF}, 32'h100);
    cycle(); settle();
    check("lit addiu out_valid", 64'(out_valid), 64'd1);
    check("lit addiu control",   64'(control),   64'(C_WE | C_I));
    check("lit addiu rd_out",    64'(rd_out),    64'd2);
    check("lit addiu imm_ext",   64'(imm_ext),   64'hFFFF_FFFF);

    // ORI r3,r0,0x8000 then LUI r3,0x1234
    put({6'b001101, 5'd0, 5'd3, 16'h8000}, 32'h104);
    cycle(); settle();
    check("lit ori imm_ext", 64'(imm_ext), 64'h0000_8000);
    put({6'b001111, 5'd0, 5'd3, 16'h1234}, 32'h108);
    cycle(); settle();
    check("lit lui imm_ext", 64'(imm_ext), 64'h1234_0000);

    // LW r5,0(r1) followed by dependent ADDU r6,r5,r5
    put({6'b100011, 5'd1, 5'd5, 16'h0000}, 32'h10C);
    cycle();
    put({6'b000000, 5'd5, 5'd5, 5'd6, 5'd0, 6'b100001}, 32'h110);
    settle();
    check("lit lw control",    64'(control),   64'(C_WE | C_I | C_LD));
    check("lit hazard stall",  64'(stall_out), 64'd1);
    cycle(); settle();
    check("lit bubble valid",  64'(out_valid), 64'd0);
    check("lit bubble ctrl",   64'(control),   64'd0);
    cycle(); settle();
    check("lit addu valid",    64'(out_valid), 64'd1);
    check("lit addu rd_out",   64'(rd_out),    64'd6);

    // Same-cycle write-back bypass: ADDU r8,r7,r0 while r7 <- 0xDEADBEEF
    put({6'b000000, 5'd7, 5'd0, 5'd8, 5'd0, 6'b100001}, 32'h114);
    wb_we = 1'b1; wb_rd = 5'd7; wb_data = 32'hDEAD_BEEF;
    cycle();
    wb_we = 1'b0;
    settle();
    check("lit bypass rs_data", 64'(rs_data), 64'hDEAD_BEEF);
    check("lit bypass rt_data", 64'(rt_data), 64'd0);

    // BEQ, JAL, illegal opcode
    put({6'b000100, 5'd1, 5'd2, 16'h0004}, 32'h118);
    cycle(); settle();
    check("lit beq control", 64'(control), 64'(C_J | C_BR));
    check("lit beq rd_out",  64'(rd_out),  64'd0);
    put({6'b000011, 26'h10}, 32'h11C);
    cycle(); settle();
    check("lit jal control", 64'(control), 64'(C_J | C_JP | C_WE));
    check("lit jal rd_out",  64'(rd_out),  64'd31);
    put({6'b111111, 26'h123}, 32'h120);
    cycle(); settle();
    check("lit illegal control", 64'(control), 64'(C_IL));

    // Stall for two cycles, then flush while stalled
    put({6'b001001, 5'd0, 5'd9, 16'h0005}, 32'h124);
    cycle();
    stall_in = 1'b1;
    put({6'b001101, 5'd1, 5'd4, 16'h7777}, 32'h128);
    cycle(); cycle(); settle();
    check("lit stall rd_out",  64'(rd_out),  64'd9);
    check("lit stall imm_ext", 64'(imm_ext), 64'd5);
    check("lit stall pc_out",  64'(pc_out),  64'h124);
    flush = 1'b1;
    cycle(); settle();
    check("lit flush valid",   64'(out_valid), 64'd0);
    check("lit flush control", 64'(control),   64'd0);
    check("lit flush rd hold", 64'(rd_out),    64'd9);
    flush = 1'b0; stall_in = 1'b0;

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      if (!stall_out || $urandom_range(0, 9) == 0) begin
        insn = rand_insn();
        pc   = $urandom;
      end
      insn_valid = ($urandom_range(0, 99) < 85);
      stall_in   = ($urandom_range(0, 99) < 10);
      flush      = ($urandom_range(0, 99) < 5);
      wb_we      = ($urandom_range(0, 1) != 0);
      wb_rd      = 5'($urandom_range(0, 7));
      wb_data    = $urandom;
      if (n == 300) reset = 1'b1;
      else          reset = 1'b0;
      cycle();
    end
    reset = 1'b0; stall_in = 1'b0; flush = 1'b0; wb_we = 1'b0;
    cycle(); settle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
